// File: rtl/spi_controller.sv
// spi_controller: byte-oriented SPI mode-0 initiator (CPOL=0, CPHA=0, MSB first).
//
// Drives spi_clk / spi_mosi / spi_cs_n and samples spi_miso on the controller's
// own SCK rising edge. Bytes come in over a valid/ready handshake. Chip select
// stays low between bytes until a byte tagged tx_last has been shifted.
//
// Ports
//   clk_in    in   system clock, all logic on posedge
//   rst_n     in   synchronous active-low reset
//   tx_valid  in   byte offered
//   tx_ready  out  byte accepted on a cycle with tx_valid && tx_ready
//   tx_data   in   byte to send, MSB first
//   tx_last   in   release CS after this byte
//   rx_valid  out  one-cycle pulse, rx_data holds the byte just received
//   rx_data   out  received byte, stable until the next rx_valid
//   busy      out  CS low, or the CS idle gap has not yet elapsed
//   spi_clk   out  SCK, idle low
//   spi_mosi  out  controller data out
//   spi_miso  in   peripheral data in (already synchronous to clk_in)
//   spi_cs_n  out  chip select, active low
module spi_controller #(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs_n
);

  // One down-counter serves every timed interval, so it is sized for the largest.
  localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_B = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int MAX_N = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_N + 1);

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DIV   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_SETUP = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] CNT_HOLD  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] CNT_IDLE  = CW'(CS_IDLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic          phase_hi_q, phase_hi_d;
  logic          last_q, last_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          tx_ready_q, tx_ready_d;
  logic          rx_valid_q, rx_valid_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          busy_q, busy_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic          cs_n_q, cs_n_d;
  logic          accept_s;

  assign accept_s = tx_valid && tx_ready_q;

  // Next-state and next-output computation for the whole controller.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    phase_hi_d = phase_hi_q;
    last_d     = last_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    tx_ready_d = tx_ready_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d    = ST_SETUP;
          cnt_d      = CNT_SETUP;
          tx_sh_d    = tx_data;
          last_d     = tx_last;
          mosi_d     = tx_data[7];
          cs_n_d     = 1'b0;
          sck_d      = 1'b0;
          tx_ready_d = 1'b0;
        end else begin
          // tx_ready comes up one cycle after reset or after the gap ends.
          tx_ready_d = 1'b1;
          cs_n_d     = 1'b1;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d    = ST_SHIFT;
          cnt_d      = CNT_DIV;
          bit_d      = 3'd7;
          phase_hi_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (!phase_hi_q) begin
          // LO->HI edge: raise SCK and capture MISO into the LSB.
          sck_d      = 1'b1;
          phase_hi_d = 1'b1;
          rx_sh_d    = {rx_sh_q[6:0], spi_miso};
          cnt_d      = CNT_DIV;
        end else if (bit_q != 3'd0) begin
          sck_d      = 1'b0;
          phase_hi_d = 1'b0;
          bit_d      = bit_q - 3'd1;
          tx_sh_d    = {tx_sh_q[6:0], 1'b0};
          mosi_d     = tx_sh_q[6];
          cnt_d      = CNT_DIV;
        end else begin
          // End of bit 0: byte complete, bit 0 was captured on the last rising edge.
          sck_d      = 1'b0;
          phase_hi_d = 1'b0;
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
          if (last_q) begin
            state_d = ST_HOLD;
            cnt_d   = CNT_HOLD;
          end else begin
            state_d    = ST_WAIT;
            tx_ready_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (accept_s) begin
          // Chained byte: CS is already low, so skip setup.
          state_d    = ST_SHIFT;
          cnt_d      = CNT_DIV;
          bit_d      = 3'd7;
          phase_hi_d = 1'b0;
          tx_sh_d    = tx_data;
          last_d     = tx_last;
          mosi_d     = tx_data[7];
          tx_ready_d = 1'b0;
        end else begin
          tx_ready_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          cs_n_d  = 1'b1;
          state_d = ST_GAP;
          cnt_d   = CNT_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d    = ST_IDLE;
          tx_ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        tx_ready_d = 1'b0;
        cs_n_d     = 1'b1;
        sck_d      = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs, with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= 3'd0;
      phase_hi_q <= 1'b0;
      last_q     <= 1'b0;
      tx_sh_q    <= 8'h00;
      rx_sh_q    <= 8'h00;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      phase_hi_q <= phase_hi_d;
      last_q     <= last_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      busy_q     <= busy_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign busy     = busy_q;
  assign spi_clk  = sck_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: self-checking bench for spi_controller.
// A CLK_DIV=2 instance is exercised in loopback and against a behavioural
// mode-0 peripheral that echoes the previous byte it received; a CLK_DIV=1
// instance checks the fastest SCK with MISO held high.
module tb_spi_controller;

  localparam int CLK_DIV  = 2;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_IDLE  = 2;
  localparam int BYTE_CYC = 16 * CLK_DIV;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0, tx_last = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, rx_valid, busy, spi_clk, spi_mosi, spi_cs_n;
  logic [7:0] rx_data;
  logic       spi_miso;
  logic       miso_mode = 1'b0;   // 0: loopback mosi->miso, 1: peripheral model

  logic       tx_valid1 = 1'b0, tx_last1 = 1'b0;
  logic [7:0] tx_data1 = 8'h00;
  logic       tx_ready1, rx_valid1, busy1, sck1, mosi1, cs_n1;
  logic [7:0] rx_data1;
  logic       miso1 = 1'b1;

  spi_controller #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)) u_dut (
    .clk_in(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_last(tx_last), .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
  );

  spi_controller #(.CLK_DIV(1), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)) u_dut1 (
    .clk_in(clk), .rst_n(rst_n), .tx_valid(tx_valid1), .tx_ready(tx_ready1), .tx_data(tx_data1),
    .tx_last(tx_last1), .rx_valid(rx_valid1), .rx_data(rx_data1), .busy(busy1), .spi_clk(sck1),
    .spi_mosi(mosi1), .spi_miso(miso1), .spi_cs_n(cs_n1)
  );

  // Behavioural mode-0 peripheral: returns the previous complete byte it received.
  logic [7:0] per_in = 8'h00, per_out = 8'h00;
  int         per_bits = 0;
  logic [2:0] per_idx = 3'd0;
  logic       per_sck_prev = 1'b0, per_cs_prev = 1'b1;
  logic       per_miso;

  always @(negedge clk) begin
    if (!rst_n) begin
      per_in = 8'h00; per_out = 8'h00; per_bits = 0; per_idx = 3'd0;
    end else begin
      if (per_cs_prev && !spi_cs_n) begin per_bits = 0; per_idx = 3'd0; end
      if (!spi_cs_n && spi_clk && !per_sck_prev) begin
        per_in = {per_in[6:0], spi_mosi};
        per_bits++;
      end
      if (!spi_cs_n && !spi_clk && per_sck_prev) begin
        if (per_bits == 8) begin per_out = per_in; per_bits = 0; per_idx = 3'd0; end
        else per_idx = per_idx + 3'd1;
      end
    end
    per_sck_prev = spi_clk;
    per_cs_prev  = spi_cs_n;
  end

  assign per_miso = per_out[3'd7 - per_idx];
  always_comb spi_miso = miso_mode ? per_miso : spi_mosi;

  // Monitor state and scoreboard
  int         n_pass = 0, n_total = 0;
  int         cyc = 0;
  logic       sck_prev = 1'b0, cs_prev = 1'b1;
  int         sck_rises, cs_rises, cs_rise_cyc;
  logic       mosi_at_rise[$];
  int         sck_rise_cyc[$];
  logic [7:0] rx_q[$];
  int         rx_cyc_q[$];
  int         acc_q[$];
  logic [7:0] txq[$];
  logic [7:0] exp_q[$];
  logic       timeout;
  logic [7:0] ref_last = 8'h00;   // last full byte the peripheral has received

  task automatic tick();
    @(posedge clk); #1; cyc++;
    if (spi_clk && !sck_prev) begin
      sck_rises++; mosi_at_rise.push_back(spi_mosi); sck_rise_cyc.push_back(cyc);
    end
    if (spi_cs_n && !cs_prev) begin cs_rises++; cs_rise_cyc = cyc; end
    sck_prev = spi_clk;
    cs_prev  = spi_cs_n;
    if (rx_valid) begin rx_q.push_back(rx_data); rx_cyc_q.push_back(cyc); end
  endtask

  task automatic clear_mon();
    sck_rises = 0; cs_rises = 0; cs_rise_cyc = -1; timeout = 1'b0;
    mosi_at_rise.delete(); sck_rise_cyc.delete(); rx_q.delete(); rx_cyc_q.delete();
    acc_q.delete(); exp_q.delete();
  endtask

  // Reference: loopback returns the byte itself, the peripheral returns the previous one.
  task automatic model_byte(input logic [7:0] d, output logic [7:0] e);
    e = miso_mode ? ref_last : d;
    ref_last = d;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    tx_valid = 1'b1; tx_data = d; tx_last = last;
    while (tx_ready !== 1'b1 && n < 2000) begin tick(); n++; end
    if (n >= 2000) timeout = 1'b1;
    tick();
    acc_q.push_back(cyc);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(spi_cs_n === 1'b1 && tx_ready === 1'b1 && busy === 1'b0) && n < 2000) begin tick(); n++; end
    if (n >= 2000) timeout = 1'b1;
  endtask

  task automatic run_txn();
    logic [7:0] e;
    for (int k = 0; k < txq.size(); k++) begin model_byte(txq[k], e); exp_q.push_back(e); end
    for (int k = 0; k < txq.size(); k++) send(txq[k], (k == txq.size() - 1));
    wait_idle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(); tick();
    rst_n = 1'b1; tick();
    ref_last = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(); tick();
    n_total++; if (spi_cs_n !== 1'b1) $display("FAIL reset_cs_n got %b exp 1", spi_cs_n); else n_pass++;
    n_total++; if (spi_clk !== 1'b0) $display("FAIL reset_sck got %b exp 0", spi_clk); else n_pass++;
    n_total++; if (spi_mosi !== 1'b0) $display("FAIL reset_mosi got %b exp 0", spi_mosi); else n_pass++;
    n_total++; if (tx_ready !== 1'b0) $display("FAIL reset_tx_ready got %b exp 0", tx_ready); else n_pass++;
    n_total++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid got %b exp 0", rx_valid); else n_pass++;
    n_total++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data got %h exp 00", rx_data); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    n_total++; if (cs_n1 !== 1'b1) $display("FAIL reset_cs_n1 got %b exp 1", cs_n1); else n_pass++;
    rst_n = 1'b1; tick();
    ref_last = 8'h00;
    n_total++; if (tx_ready !== 1'b1) $display("FAIL post_reset_tx_ready got %b exp 1", tx_ready); else n_pass++;
  endtask

  task automatic test_single();
    logic [7:0] mbits;
    miso_mode = 1'b0; clear_mon();
    txq = '{8'hA5};
    run_txn();
    mbits = 8'h00;
    for (int i = 0; i < 8 && i < mosi_at_rise.size(); i++) mbits[7-i] = mosi_at_rise[i];
    n_total++; if (timeout !== 1'b0) $display("FAIL single_timeout"); else n_pass++;
    n_total++; if (rx_q.size() != 1) $display("FAIL single_rx_count got %0d exp 1", rx_q.size()); else n_pass++;
    n_total++; if (rx_q[0] !== exp_q[0]) $display("FAIL single_rx_data got %h exp %h", rx_q[0], exp_q[0]); else n_pass++;
    n_total++; if (rx_cyc_q[0] - acc_q[0] != CS_SETUP + BYTE_CYC)
      $display("FAIL single_latency got %0d exp %0d", rx_cyc_q[0] - acc_q[0], CS_SETUP + BYTE_CYC); else n_pass++;
    n_total++; if (sck_rises != 8) $display("FAIL single_sck_rises got %0d exp 8", sck_rises); else n_pass++;
    n_total++; if (mbits !== 8'hA5) $display("FAIL single_mosi_pattern got %h exp a5", mbits); else n_pass++;
    n_total++; if (cs_rise_cyc - rx_cyc_q[0] != CS_HOLD)
      $display("FAIL single_cs_hold got %0d exp %0d", cs_rise_cyc - rx_cyc_q[0], CS_HOLD); else n_pass++;
  endtask

  task automatic test_multi();
    do_reset();
    miso_mode = 1'b1; clear_mon();
    txq = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_txn();
    n_total++; if (timeout !== 1'b0) $display("FAIL multi_timeout"); else n_pass++;
    n_total++; if (rx_q.size() != 4) $display("FAIL multi_rx_count got %0d exp 4", rx_q.size()); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++; if (rx_q[k] !== exp_q[k]) $display("FAIL multi_rx_data[%0d] got %h exp %h", k, rx_q[k], exp_q[k]); else n_pass++;
    end
    n_total++; if (exp_q[0] !== 8'h00 || exp_q[3] !== 8'h03) $display("FAIL multi_model got %h..%h exp 00..03", exp_q[0], exp_q[3]); else n_pass++;
    n_total++; if (sck_rises != 32) $display("FAIL multi_sck_rises got %0d exp 32", sck_rises); else n_pass++;
    n_total++; if (cs_rises != 1 || cs_rise_cyc <= rx_cyc_q[3])
      $display("FAIL multi_cs_continuous got rises=%0d at %0d exp 1 after %0d", cs_rises, cs_rise_cyc, rx_cyc_q[3]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    miso_mode = 1'b0; clear_mon();
    txq.delete();
    for (int k = 0; k < 3; k++) txq.push_back(8'($urandom));
    run_txn();
    n_total++; if (rx_q.size() != 3) $display("FAIL b2b_rx_count got %0d exp 3", rx_q.size()); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_total++; if (rx_q[k] !== exp_q[k]) $display("FAIL b2b_rx_data[%0d] got %h exp %h", k, rx_q[k], exp_q[k]); else n_pass++;
    end
    for (int k = 0; k < 2; k++) begin
      n_total++; if (acc_q[k+1] != rx_cyc_q[k] + 1)
        $display("FAIL b2b_accept[%0d] got %0d exp %0d", k + 1, acc_q[k+1], rx_cyc_q[k] + 1); else n_pass++;
      n_total++; if (sck_rise_cyc[8*(k+1)] != acc_q[k+1] + CLK_DIV)
        $display("FAIL b2b_first_rise[%0d] got %0d exp %0d", k + 1, sck_rise_cyc[8*(k+1)], acc_q[k+1] + CLK_DIV); else n_pass++;
      n_total++; if (rx_cyc_q[k+1] - acc_q[k+1] != BYTE_CYC)
        $display("FAIL b2b_latency[%0d] got %0d exp %0d", k + 1, rx_cyc_q[k+1] - acc_q[k+1], BYTE_CYC); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    miso_mode = 1'b0; clear_mon();
    send(8'($urandom), 1'b1);
    n = 0;
    while (sck_rises < 3 && n < 500) begin tick(); n++; end
    n_total++; if (sck_rises != 3) $display("FAIL midrst_reach got %0d exp 3", sck_rises); else n_pass++;
    rst_n = 1'b0; tick();
    n_total++; if (spi_cs_n !== 1'b1) $display("FAIL midrst_cs_n got %b exp 1", spi_cs_n); else n_pass++;
    n_total++; if (spi_clk !== 1'b0) $display("FAIL midrst_sck got %b exp 0", spi_clk); else n_pass++;
    rst_n = 1'b1;
    ref_last = 8'h00;
    for (int i = 0; i < 40; i++) tick();
    n_total++; if (rx_q.size() != 0) $display("FAIL midrst_no_rx got %0d exp 0", rx_q.size()); else n_pass++;
    clear_mon();
    txq = '{8'($urandom)};
    run_txn();
    n_total++; if (rx_q[0] !== exp_q[0] || rx_q.size() != 1) $display("FAIL midrst_fresh got %h exp %h", rx_q[0], exp_q[0]); else n_pass++;
    n_total++; if (rx_cyc_q[0] - acc_q[0] != CS_SETUP + BYTE_CYC)
      $display("FAIL midrst_latency got %0d exp %0d", rx_cyc_q[0] - acc_q[0], CS_SETUP + BYTE_CYC); else n_pass++;
  endtask

  task automatic test_ignore();
    int n, r1;
    logic [7:0] e;
    miso_mode = 1'b0; clear_mon();
    txq = '{8'($urandom)};
    model_byte(txq[0], e);
    send(txq[0], 1'b1);
    n = 0;
    while (tx_ready !== 1'b1 && n < 500) begin
      tx_valid = (($urandom % 2) == 1);
      tx_data  = 8'($urandom);
      tx_last  = 1'b0;
      tick(); n++;
    end
    tx_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    n_total++; if (rx_q.size() != 1 || rx_q[0] !== e) $display("FAIL ignore_rx got n=%0d %h exp 1 %h", rx_q.size(), rx_q[0], e); else n_pass++;
    n_total++; if (sck_rises != 8) $display("FAIL ignore_sck_rises got %0d exp 8", sck_rises); else n_pass++;
    n_total++; if (spi_cs_n !== 1'b1 || busy !== 1'b0) $display("FAIL ignore_idle got cs_n=%b busy=%b exp 1 0", spi_cs_n, busy); else n_pass++;
    clear_mon();
    txq = '{8'($urandom), 8'($urandom)};
    model_byte(txq[0], e); exp_q.push_back(e);
    model_byte(txq[1], e); exp_q.push_back(e);
    send(txq[0], 1'b1);
    send(txq[1], 1'b1);
    r1 = cs_rise_cyc;
    wait_idle();
    n_total++; if (!(r1 > 0 && acc_q[1] - r1 >= CS_IDLE)) $display("FAIL ignore_cs_idle got %0d exp >=%0d", acc_q[1] - r1, CS_IDLE); else n_pass++;
    n_total++; if (rx_q[0] !== exp_q[0] || rx_q[1] !== exp_q[1])
      $display("FAIL ignore_pair_rx got %h %h exp %h %h", rx_q[0], rx_q[1], exp_q[0], exp_q[1]); else n_pass++;
  endtask

  task automatic test_clkdiv1();
    int n, acc1, rxc;
    logic       prev;
    logic [7:0] rxd;
    int         rises[$];
    tx_valid1 = 1'b1; tx_data1 = 8'($urandom); tx_last1 = 1'b1;
    n = 0;
    while (tx_ready1 !== 1'b1 && n < 100) begin tick(); n++; end
    tick(); acc1 = cyc; tx_valid1 = 1'b0;
    prev = sck1; rxc = -1; rxd = 8'h00;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (sck1 && !prev) rises.push_back(cyc);
      prev = sck1;
      if (rx_valid1) begin rxc = cyc; rxd = rx_data1; end
    end
    n_total++; if (rxc - acc1 != CS_SETUP + 16) $display("FAIL div1_latency got %0d exp %0d", rxc - acc1, CS_SETUP + 16); else n_pass++;
    n_total++; if (rxd !== 8'hFF) $display("FAIL div1_rx_data got %h exp ff", rxd); else n_pass++;
    n_total++; if (rises.size() != 8) $display("FAIL div1_rises got %0d exp 8", rises.size()); else n_pass++;
    n_total++; if (rises[1] - rises[0] != 2) $display("FAIL div1_period got %0d exp 2", rises[1] - rises[0]); else n_pass++;
    n_total++; if (rises[0] != acc1 + CS_SETUP + 1) $display("FAIL div1_first_rise got %0d exp %0d", rises[0], acc1 + CS_SETUP + 1); else n_pass++;
  endtask

  task automatic test_random();
    int len, first_err;
    for (int t = 0; t < 6; t++) begin
      miso_mode = (($urandom % 2) == 1);
      clear_mon();
      len = $urandom_range(1, 3);
      txq.delete();
      for (int k = 0; k < len; k++) txq.push_back(8'($urandom));
      run_txn();
      first_err = -1;
      for (int k = 0; k < len; k++) if (rx_q[k] !== exp_q[k] && first_err < 0) first_err = k;
      n_total++; if (timeout !== 1'b0 || rx_q.size() != len || first_err >= 0)
        $display("FAIL rand_rx[%0d] got n=%0d err_at=%0d exp n=%0d", t, rx_q.size(), first_err, len); else n_pass++;
      n_total++; if (rx_cyc_q[0] - acc_q[0] != CS_SETUP + BYTE_CYC || rx_cyc_q[len-1] - acc_q[len-1] != ((len == 1) ? CS_SETUP + BYTE_CYC : BYTE_CYC))
        $display("FAIL rand_latency[%0d] got %0d exp %0d", t, rx_cyc_q[0] - acc_q[0], CS_SETUP + BYTE_CYC); else n_pass++;
      n_total++; if (sck_rises != 8 * len) $display("FAIL rand_sck_rises[%0d] got %0d exp %0d", t, sck_rises, 8 * len); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_back_to_back();
    test_reset_mid();
    test_ignore();
    test_clkdiv1();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
